// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch front end.
// IM_ADDR_BIT is the instruction memory word-address width used across the core.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 16
`endif

package fetch_pkg;

  localparam int INST_W      = 32;
  localparam int IM_ADDR_BIT = `IM_ADDR_BIT;

  typedef struct packed {
    logic [IM_ADDR_BIT-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO of fetched {pc, inst} entries with a combinational head.
// Clear drops every entry by snapping the read pointer onto the write pointer.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  // Storage is not reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues instruction memory reads at the current PC under a credit
// limit and queues returned instructions with their PCs for decode.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = `IM_ADDR_BIT,
  parameter int INST_W = fetch_pkg::INST_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [INST_W-1:0] im_data,
  input  logic              flush,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic              inflight;
  logic [ADDR_W-1:0] req_pc;
  logic [CW-1:0]     count;
  logic [CW:0]       used;
  logic              issue;
  logic              push;
  logic              pop;
  entry_t            push_data;
  entry_t            head;

  // A slot is reserved for the in-flight read at issue time, so the response
  // always has room even if decode stalls in the meantime.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = !rst && !flush && (used < (CW + 1)'(DEPTH));

  assign im_req  = issue;
  assign pc_en   = issue || (flush && !rst);
  assign im_addr = pc;

  assign inst_valid = !rst && !flush && (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  assign push      = inflight && !flush;
  assign pop       = inst_valid && inst_ready;
  assign push_data = '{pc: req_pc, inst: im_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      req_pc   <= '0;
    end else if (issue) begin
      inflight <= 1'b1;
      req_pc   <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (flush),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized self-checking bench for inst_fetch_queue against a queue-level model
// of the fetch credit rules, plus directed reset/stream/backpressure/flush scenarios.
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  localparam int AW    = IM_ADDR_BIT;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          pc_en;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_data;
  logic          flush;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  inst_fetch_queue #(
    .ADDR_W (AW),
    .INST_W (IW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_en      (pc_en),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_data    (im_data),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: the queue holds PCs of buffered instructions; pend marks one read in flight.
  logic [AW-1:0] model_q[$];
  logic          pend = 1'b0;
  logic [AW-1:0] pend_pc = '0;

  // Environment state: program counter and instruction memory response.
  logic [AW-1:0] pc_next = '0;
  logic          im_pend = 1'b0;
  logic [AW-1:0] im_pend_addr = '0;
  logic [AW-1:0] flush_target = '0;

  // Snapshot of DUT outputs for directed literal checks.
  logic          s_pc_en, s_im_req, s_valid;
  logic [AW-1:0] s_im_addr, s_inst_pc;
  logic [IW-1:0] s_inst;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + IW'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic rdy,
                               input logic [AW-1:0] tgt);
    @(negedge clk);
    pc           = pc_next;
    im_data      = im_pend ? mem_word(im_pend_addr) : IW'($urandom);
    rst          = r;
    flush        = f;
    inst_ready   = rdy;
    flush_target = tgt;
  endtask

  task automatic checkOutput();
    logic exp_valid, exp_issue, exp_pc_en;
    #1;
    exp_valid = !rst && !flush && (model_q.size() != 0);
    exp_issue = !rst && !flush && (model_q.size() + int'(pend) < DEPTH);
    exp_pc_en = exp_issue || (flush && !rst);
    chk("pc_en", 64'(pc_en), 64'(exp_pc_en));
    chk("im_req", 64'(im_req), 64'(exp_issue));
    chk("inst_valid", 64'(inst_valid), 64'(exp_valid));
    if (exp_issue) chk("im_addr", 64'(im_addr), 64'(pc));
    if (exp_valid) begin
      chk("inst_pc", 64'(inst_pc), 64'(model_q[0]));
      chk("inst", 64'(inst), 64'(mem_word(model_q[0])));
    end
    s_pc_en = pc_en; s_im_req = im_req; s_valid = inst_valid;
    s_im_addr = im_addr; s_inst_pc = inst_pc; s_inst = inst;

    if (rst || flush) begin
      model_q.delete();
      pend = 1'b0;
    end else begin
      if (exp_valid && inst_ready) void'(model_q.pop_front());
      if (pend) model_q.push_back(pend_pc);
      pend    = exp_issue;
      pend_pc = pc;
    end

    if (rst)        pc_next = '0;
    else if (flush) pc_next = flush_target;
    else if (pc_en) pc_next = pc + AW'(1);
    else            pc_next = pc;
    im_pend      = im_req;
    im_pend_addr = im_addr;
  endtask

  task automatic step(input logic r, input logic f, input logic rdy,
                      input logic [AW-1:0] tgt = '0);
    applyStimulus(r, f, rdy, tgt);
    checkOutput();
  endtask

  task automatic doReset(input logic rdy);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, rdy);
      chk("rst_pc_en", 64'(s_pc_en), 64'd0);
      chk("rst_valid", 64'(s_valid), 64'd0);
    end
  endtask

  initial begin
    int nreq;
    rst = 1'b1; flush = 1'b0; inst_ready = 1'b0; pc = '0; im_data = '0;

    // Reset then streaming with decode always ready.
    doReset(1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("first_req", 64'(s_im_req), 64'd1);
    chk("first_addr", 64'(s_im_addr), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("no_bypass", 64'(s_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("stream_valid", 64'(s_valid), 64'd1);
      chk("stream_pc", 64'(s_inst_pc), 64'(k));
      chk("stream_inst", 64'(s_inst), 64'(32'h1000_0000 + k));
    end

    // Backpressure: exactly DEPTH requests, then drain in order.
    doReset(1'b0);
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (s_im_req) begin
        chk("bp_addr", 64'(s_im_addr), 64'(nreq));
        nreq++;
      end
    end
    chk("bp_reqs", 64'(nreq), 64'd4);
    chk("bp_stall", 64'(s_pc_en), 64'd0);
    chk("bp_pc_hold", 64'(pc_next), 64'd4);
    step(1'b0, 1'b0, 1'b1);
    chk("bp_head0", 64'(s_inst_pc), 64'd0);
    chk("bp_noreq_on_pop", 64'(s_im_req), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("bp_resume", 64'(s_im_req), 64'd1);
    chk("bp_resume_addr", 64'(s_im_addr), 64'd4);
    chk("bp_head1", 64'(s_inst_pc), 64'd1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1);

    // Flush with 2 entries queued and 1 in flight.
    doReset(1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, AW'(16'h40));
    chk("flush_valid", 64'(s_valid), 64'd0);
    chk("flush_pc_en", 64'(s_pc_en), 64'd1);
    chk("flush_noreq", 64'(s_im_req), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("flush_req", 64'(s_im_req), 64'd1);
    chk("flush_addr", 64'(s_im_addr), 64'h40);
    chk("flush_empty", 64'(s_valid), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("flush_gap", 64'(s_valid), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("flush_tgt_valid", 64'(s_valid), 64'd1);
    chk("flush_tgt_pc", 64'(s_inst_pc), 64'h40);

    // Reset and flush together: reset wins.
    step(1'b1, 1'b1, 1'b1, AW'(16'h55));
    chk("rstflush_pc_en", 64'(s_pc_en), 64'd0);
    chk("rstflush_req", 64'(s_im_req), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("rstflush_addr", 64'(s_im_addr), 64'd0);
    chk("rstflush_req2", 64'(s_im_req), 64'd1);

    // Randomized traffic: exercises push/pop/wrap combinations against the model.
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < 6,
           AW'($urandom));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end on the consumer side of the program counter. Takes the current PC, drives the PC's advance enable, issues reads to the synchronous instruction memory, and buffers returned instructions with their PCs for decode under a valid/ready handshake. On redirect (`flush`), it discards everything queued or in flight.

## Interface
- `ADDR_W`, default `` `IM_ADDR_BIT ``: instruction word address width. Word addressing: next sequential is pc+1.
- `INST_W`, default 32: instruction width.
- `DEPTH`, default 4: queue entries. Power of two, ≥2.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `pc`  in  ADDR_W  current PC from the program counter.
- `pc_en`  out  1  advance enable to the program counter.
- `im_req`  out  1  instruction memory read strobe.
- `im_addr`  out  ADDR_W  read address; equals `pc`.
- `im_data`  in  INST_W  read data, valid the cycle after `im_req`.
- `flush`  in  1  redirect; the PC loads the target this cycle.
- `inst_valid`  out  1  head entry valid.
- `inst`  out  INST_W  head instruction.
- `inst_pc`  out  ADDR_W  PC of head instruction.
- `inst_ready`  in  1  decode accepts head when `inst_valid & inst_ready`.

## Operation
- State:
  - `count` (0..DEPTH) for queued entries.
  - `inflight` (0/1) for an outstanding read.
  - `req_pc` register for the address of the outstanding read.
  - `rd_ptr`/`wr_ptr` (log2 DEPTH bits, wrap modulo DEPTH).
- Issue condition:
  - `issue = !rst & !flush & (count + inflight < DEPTH)`.
  - `im_req = pc_en = issue`, except that on a flush `pc_en = 1` and `im_req = 0`.
- On issue: `inflight <= 1`, `req_pc <= pc`. Otherwise `inflight <= 0`.
- Response: if `inflight & !flush`, write `{req_pc, im_data}` at `wr_ptr`, then `wr_ptr++`.
- Pop: if `inst_valid & inst_ready & !flush`, then `rd_ptr++`.
- Push and pop in the same cycle: `count` unchanged, both pointers advance.
- Flush, same cycle:
  - `count <= 0`, `rd_ptr <= wr_ptr`, `inflight <= 0`.
  - The response arriving this cycle is dropped.
  - `inst_valid = 0` combinationally, so no pop occurs.
- `inst_valid = (count != 0) & !flush`. `inst` and `inst_pc` read combinationally from `rd_ptr`.
- Full (`count + inflight == DEPTH`): `pc_en = 0` and the PC holds. The pending response still fits because credit was reserved at issue.
- Empty: `inst_valid = 0`, and `inst`/`inst_pc` are don't-care.
- Behaviour is undefined if `count` would exceed DEPTH; the credit rule makes this unreachable.

## Timing
- Reset, sampled at posedge, clears `count`, `inflight`, both pointers, and `req_pc` (to 0).
- While `rst = 1`: `pc_en = im_req = inst_valid = 0`. `rst` has priority over `flush`.
- Fetch latency: request in cycle N, data captured at the end of N+1, `inst_valid` high in N+2. No bypass.
- Throughput: one instruction per cycle sustained while decode is always ready (steady `count` ≤ 1).
- After a flush in cycle F: first request at the target PC in F+1, `inst_valid` for the target in F+3.
- Reset mid-operation: queued and in-flight data are lost. The first request is issued in the cycle after `rst` deasserts.

## Structure
- Shared package `fetch_pkg`:
  - `INST_W = 32`
  - the `` `IM_ADDR_BIT `` alias
  - packed struct `fetch_entry_t {pc, inst}`
- Sub-module `fetch_fifo`: synchronous DEPTH-entry FIFO of `fetch_entry_t`.
  - Ports: push, pop, clear, `count`, head.
  - `inst_fetch_queue` keeps the credit/inflight logic and the PC/IM control.

## Test plan
- **Reset:** `rst = 1` for 3 cycles → `pc_en = im_req = inst_valid = 0`. First `im_req` with `im_addr = 0` in the cycle after release.
- **Streaming:** IM returns `0x1000_0000 + addr`, `inst_ready = 1` → `inst_valid` from cycle 3 after reset release, then one per cycle with `inst_pc` = 0, 1, 2, ….
- **Backpressure:** `inst_ready = 0` from start, DEPTH = 4 → exactly 4 requests (addr 0–3), then `pc_en = 0`. Queue holds pc 0..3. Raising `inst_ready` drains in order and resumes fetch at pc 4 on the cycle after the first pop.
- **Flush:** `flush` pulse with 2 entries queued and 1 in flight, PC target 0x40 → `inst_valid = 0` that cycle. Next request at 0x40. The next `inst_pc` delivered is 0x40; no stale entry appears.
- **Simultaneous events:** push, pop, and wrap at `wr_ptr = 3` → `count` stable and ordering preserved across wrap. Assert `flush` and `rst` together → reset behaviour wins.
